// File: rtl/ram_fifo_ctrl_pkg.sv
// rtl/ram_fifo_ctrl_pkg.sv - shared helpers for the RAM-backed FIFO controller
package ram_fifo_ctrl_pkg;

   // The pointers wrap by natural overflow, so the RAM must be exactly 2**aw deep.
   function automatic bit depth_matches(input int depth, input int aw);
      return depth == (1 << aw);
   endfunction

endpackage

// File: rtl/ram_fifo.sv
// rtl/ram_fifo.sv - FIFO built from ram_fifo_ctrl and its single-port RAM
module ram_fifo #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH+1:0] count
);

   logic                  ram_we;
   logic                  ram_re;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   ram_fifo_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .ram_we    (ram_we),
      .ram_re    (ram_re),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .count     (count)
   );

   sp_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port synchronous RAM, registered read, 1-cycle latency
module sp_ram #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/wrap_ptr.sv
// rtl/wrap_ptr.sv - wrapping RAM pointer with increment enable
module wrap_ptr #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] ptr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= ptr + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - valid/ready FIFO controller over a single-port synchronous RAM
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  ram_we,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [ADDR_WIDTH+1:0] count
);

   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

   if (!depth_matches(DEPTH, ADDR_WIDTH)) begin : g_depth_chk
      $error("ram_fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
   end

   logic [ADDR_WIDTH:0]   ram_cnt;
   logic                  rd_pending;
   logic                  rd_req;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;

   // Prefetch only when the output register is free (or being popped) and no read is in flight.
   assign rd_req   = (ram_cnt != '0) && !rd_pending && (!out_valid || out_ready);
   assign in_ready = (ram_cnt != FULL_CNT) && !rd_req;
   assign wr_en    = in_valid && in_ready;

   assign ram_re    = rd_req;
   assign ram_we    = wr_en;
   assign ram_addr  = rd_req ? rd_ptr : wr_ptr;
   assign ram_wdata = in_data;

   assign count = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(rd_pending)
                + (ADDR_WIDTH+2)'(out_valid);

   wrap_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_en),
      .ptr   (wr_ptr)
   );

   wrap_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (rd_req),
      .ptr   (rd_ptr)
   );

   // wr_en and rd_req are mutually exclusive, so at most one adjustment applies.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_cnt <= '0;
      end else if (wr_en) begin
         ram_cnt <= ram_cnt + (ADDR_WIDTH+1)'(1);
      end else if (rd_req) begin
         ram_cnt <= ram_cnt - (ADDR_WIDTH+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= rd_req;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (rd_pending) begin
         out_valid <= 1'b1;
         out_data  <= ram_rdata;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Controller that turns the single-port synchronous RAM (one shared address, registered read, 1-cycle read latency) into a valid/ready FIFO. It sits directly upstream of the RAM: it drives the RAM's write enable, read enable, address and write data, and takes the RAM's read data. It arbitrates the single address port between pushes and prefetch reads, and presents the head entry through a one-entry output register.

## Interface
- ADDR_WIDTH, 3, RAM address width; DEPTH must equal 2**ADDR_WIDTH
- DATA_WIDTH, 8, entry width
- DEPTH, 8, RAM entries
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  push request
- in_ready  out  1  push accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  push payload
- out_valid  out  1  out_data holds the head entry
- out_ready  in  1  pop when out_valid && out_ready
- out_data  out  DATA_WIDTH  head entry
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_re
- count  out  ADDR_WIDTH+2  total entries held: ram_cnt + rd_pending + out_valid

## Operation
- State:
  - wr_ptr and rd_ptr, each ADDR_WIDTH bits, wrapping DEPTH-1 → 0.
  - ram_cnt, 0..DEPTH.
  - rd_pending, 1 bit.
  - Output register out_valid/out_data.
- Read request: rd_req = (ram_cnt != 0) && !rd_pending && (!out_valid || out_ready).
- Push acceptance: in_ready = (ram_cnt != DEPTH) && !rd_req. Reads have priority. At most one read is in flight, so writes get at least every other cycle.
- Port drive, all combinational:
  - ram_re = rd_req.
  - ram_we = in_valid && in_ready.
  - ram_addr = rd_req ? rd_ptr : wr_ptr.
  - ram_wdata = in_data.
  - ram_we and ram_re are never both 1.
- On a write: wr_ptr+1, ram_cnt+1.
- On a read issue: rd_ptr+1, ram_cnt−1, rd_pending←1.
- When rd_pending=1: out_data←ram_rdata, out_valid←1, rd_pending←0.
- A pop with no landing read clears out_valid. out_data holds its last value.
- ram_cnt change when a write and a read issue fall in the same cycle: impossible, the port is single. Only one of +1/−1 applies per cycle.
- Empty: ram_cnt=0, so no read is issued. out_valid falls after the final pop.
- Full: ram_cnt=DEPTH, so in_ready=0. Total capacity is DEPTH+1 (RAM plus output register), and count reaches DEPTH+1.
- Reset: asynchronous assert clears pointers, ram_cnt, rd_pending, out_valid, out_data (0) and count (0). RAM contents are not cleared and are treated as discarded. An in-flight read is dropped. After release, in_ready=1.

## Timing
- A push accepted in cycle t is written at the end of t.
- With an empty FIFO:
  - ram_re in t+1.
  - ram_rdata in t+2.
  - out_valid=1 in t+3.
  - Push-to-out_valid latency is 3 cycles.
- A pop in cycle t with ram_cnt>0 and no pending read gives ram_re in t and out_valid in t+2. out_valid is low in t+1 unless the output register was refilled.
- Sustained output throughput is 1 entry per 2 cycles. Writes fill the other cycles.
- Back-to-back read-after-write to the same address is safe: the write commits at the edge before the read issues.
- count updates on the clock edge following each event.

## Structure
- No shared package required. DEPTH/ADDR_WIDTH consistency is checked by an elaboration-time assertion.
- One natural sub-module: wrap_ptr, a parameterized ADDR_WIDTH wrapping incrementer with enable and async active-low reset, instantiated twice (wr_ptr, rd_ptr).
- A separate top-level wrapper, ram_fifo, instantiates ram_fifo_ctrl plus the RAM. It is the verification DUT alongside the standalone controller.

## Test plan
- Reset, then push 0x11 in cycle 0 with out_ready=0 → ram_we=1/ram_addr=0 in cycle 0, ram_re=1/ram_addr=0 in cycle 1, out_valid=1/out_data=0x11 in cycle 3, count=1.
- Fill with 0x01..0x09 and out_ready=0 → in_ready drops after 9 accepted pushes, count=9, ram_cnt=8.
- Drain the full FIFO with out_ready=1 → output order 0x01..0x09, one entry per 2 cycles, out_valid=0 and count=0 at end, no ram_re while ram_cnt=0.
- Continuous in_valid with out_ready=1 over 20 cycles:
  - ram_we and ram_re never both high.
  - Pointers wrap 7→0 correctly.
  - Output sequence equals input sequence.
- Assert rst_n mid-stream with a read pending → out_valid, count, rd_pending go 0 immediately (asynchronously). After release, push 0xA5 → it emerges as the first output.
- Hold out_valid with out_ready=0 for 5 cycles → out_data stable, no ram_re issued, pushes continue while ram_cnt<8.
